phv_deparser_trim: RTL and testbench

- Parametrised successor of the single-port segment-replace stage. It sits after the header parser's PHV FIFO and the packet FIFO.
- It rebuilds each packet on the way out:
  - the first NUM_SEG beats are replaced by PHV header segments;
  - later beats pass through unchanged;
  - the output is cut to the PHV-supplied length with a correct tkeep;
  - input beats left over after the cut are drained silently.
- Proper AXIS backpressure; one registered output stage.

---
 rtl/deparser_pkg.sv | 23 ++
 rtl/axis_out_reg.sv | 44 ++++
 rtl/phv_deparser_trim.sv | 154 +++++++++++++++
 tb/tb_phv_deparser_trim.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/deparser_pkg.sv
// Shared definitions for the PHV deparser and its output stage: FSM encoding,
// tuser field layout and the tail byte-enable helper.
package deparser_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_EMIT  = 2'd1;
  localparam logic [1:0] ST_FLUSH = 2'd2;

  localparam int unsigned LEN_LSB   = 0;
  localparam int unsigned LEN_FW    = 16;
  localparam int unsigned PORT_LSB  = 24;
  localparam int unsigned PORT_FW   = 8;
  localparam int unsigned MAX_BYTES = 128;

  // Low-order byte enables: (1 << rem) - 1, callers truncate to their beat width
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned rem);
    logic [MAX_BYTES-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < MAX_BYTES; i++) m[i] = (i < rem);
    return m;
  endfunction

endpackage

// File: rtl/axis_out_reg.sv
// Single registered AXIS output stage; the held beat stays stable while the
// consumer stalls, and a new beat is taken only when the register is free.
module axis_out_reg #(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned TUSER_WIDTH = 128,
  parameter int unsigned KEEP_WIDTH  = DATA_WIDTH / 8
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   load,
  input  logic [DATA_WIDTH-1:0]  beat_tdata,
  input  logic [KEEP_WIDTH-1:0]  beat_tkeep,
  input  logic [TUSER_WIDTH-1:0] beat_tuser,
  input  logic                   beat_tlast,
  output logic                   free_c,
  output logic [DATA_WIDTH-1:0]  m_axis_tdata,
  output logic [KEEP_WIDTH-1:0]  m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0] m_axis_tuser,
  output logic                   m_axis_tlast,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready
);

  assign free_c = !m_axis_tvalid | m_axis_tready;

  always_ff @(posedge clk) begin
    if (reset) begin
      m_axis_tdata  <= '0;
      m_axis_tkeep  <= '0;
      m_axis_tuser  <= '0;
      m_axis_tlast  <= 1'b0;
      m_axis_tvalid <= 1'b0;
    end else if (load && free_c) begin
      m_axis_tdata  <= beat_tdata;
      m_axis_tkeep  <= beat_tkeep;
      m_axis_tuser  <= beat_tuser;
      m_axis_tlast  <= beat_tlast;
      m_axis_tvalid <= 1'b1;
    end else if (m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/phv_deparser_trim.sv
// Rebuilds packets from PHV header segments plus payload passthrough, trims to
// the PHV length and drains leftover input. Optional counters: DEPARSER_STATS_EN.
module phv_deparser_trim
  import deparser_pkg::*;
#(
  parameter int unsigned DATA_WIDTH  = 256,
  parameter int unsigned TUSER_WIDTH = 128,
  parameter int unsigned NUM_SEG     = 4,
  parameter int unsigned LEN_WIDTH   = 16,
  localparam int unsigned BYTES      = DATA_WIDTH / 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [DATA_WIDTH-1:0]         s_axis_tdata,
  input  logic [BYTES-1:0]              s_axis_tkeep,
  input  logic [TUSER_WIDTH-1:0]        s_axis_tuser,
  input  logic                          s_axis_tvalid,
  output logic                          s_axis_tready,
  input  logic                          s_axis_tlast,
  input  logic [NUM_SEG*DATA_WIDTH-1:0] phv_hdr,
  input  logic [LEN_WIDTH-1:0]          phv_len,
  input  logic [7:0]                    phv_port,
  input  logic                          phv_valid,
  output logic                          phv_ready,
  output logic [DATA_WIDTH-1:0]         m_axis_tdata,
  output logic [BYTES-1:0]              m_axis_tkeep,
  output logic [TUSER_WIDTH-1:0]        m_axis_tuser,
  output logic                          m_axis_tlast,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready
`ifdef DEPARSER_STATS_EN
  ,
  output logic [31:0]                   stat_pkt_cnt,
  output logic [31:0]                   stat_trim_cnt,
  output logic [31:0]                   stat_short_cnt
`endif
);

  localparam int unsigned BYTE_SH = $clog2(BYTES);
  localparam int unsigned LW1     = LEN_WIDTH + 1;

  logic [1:0]             state, state_nxt;
  logic [LEN_WIDTH-1:0]   beat_cnt, beat_cnt_nxt;
  logic                   out_free, acc, emit, end_pkt, at_last, in_hdr, len_zero;
  logic [LW1-1:0]         len_ext, last_b, rem;
  logic [DATA_WIDTH-1:0]  beat_data;
  logic [BYTES-1:0]       beat_keep;
  logic [TUSER_WIDTH-1:0] beat_user;

  // Packet end arithmetic; BYTES is a power of two so the divide is a shift
  assign len_ext  = {1'b0, phv_len};
  assign last_b   = ((len_ext + LW1'(BYTES - 1)) >> BYTE_SH) - LW1'(1);
  assign rem      = len_ext - (last_b << BYTE_SH);
  assign len_zero = (phv_len == '0);
  assign at_last  = ({1'b0, beat_cnt} == last_b);
  assign in_hdr   = (beat_cnt < LEN_WIDTH'(NUM_SEG));
  assign end_pkt  = at_last | s_axis_tlast;

  // IDLE also waits out the PHV pop cycle, when phv_valid still shows the old entry
  assign s_axis_tready = (state == ST_IDLE)  ? (phv_valid & out_free & !phv_ready) :
                         (state == ST_EMIT)  ? out_free :
                         (state == ST_FLUSH);
  assign acc  = s_axis_tvalid & s_axis_tready;
  assign emit = acc & (state != ST_FLUSH) & !len_zero;

  always_comb begin
    state_nxt    = state;
    beat_cnt_nxt = beat_cnt;
    case (state)
      ST_IDLE: begin
        if (acc) begin
          if (len_zero || end_pkt) state_nxt = s_axis_tlast ? ST_IDLE : ST_FLUSH;
          else                     state_nxt = ST_EMIT;
        end
      end
      ST_EMIT: begin
        if (acc && end_pkt) state_nxt = s_axis_tlast ? ST_IDLE : ST_FLUSH;
      end
      ST_FLUSH: begin
        if (acc && s_axis_tlast) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (acc) begin
      if (state_nxt == ST_IDLE) beat_cnt_nxt = '0;
      else if (!(&beat_cnt))    beat_cnt_nxt = beat_cnt + LEN_WIDTH'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      beat_cnt  <= '0;
      phv_ready <= 1'b0;
    end else begin
      state     <= state_nxt;
      beat_cnt  <= beat_cnt_nxt;
      phv_ready <= acc & s_axis_tlast;
    end
  end

  // Output beat assembly: header segments, beat-0 metadata, trimmed tail keep
  always_comb begin
    beat_data = s_axis_tdata;
    for (int k = 0; k < int'(NUM_SEG); k++) begin
      if (beat_cnt == LEN_WIDTH'(k)) beat_data = phv_hdr[k*DATA_WIDTH +: DATA_WIDTH];
    end
    beat_user = s_axis_tuser;
    if (beat_cnt == '0) begin
      beat_user[LEN_LSB +: LEN_FW]   = LEN_FW'(phv_len);
      beat_user[PORT_LSB +: PORT_FW] = phv_port;
    end
    if (at_last)           beat_keep = BYTES'(keep_mask(32'(rem)));
    else if (s_axis_tlast) beat_keep = s_axis_tkeep;
    else if (in_hdr)       beat_keep = '1;
    else                   beat_keep = s_axis_tkeep;
  end

  axis_out_reg #(
    .DATA_WIDTH  (DATA_WIDTH),
    .TUSER_WIDTH (TUSER_WIDTH),
    .KEEP_WIDTH  (BYTES)
  ) u_out (
    .clk           (clk),
    .reset         (reset),
    .load          (emit),
    .beat_tdata    (beat_data),
    .beat_tkeep    (beat_keep),
    .beat_tuser    (beat_user),
    .beat_tlast    (end_pkt),
    .free_c        (out_free),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tkeep  (m_axis_tkeep),
    .m_axis_tuser  (m_axis_tuser),
    .m_axis_tlast  (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready)
  );

`ifdef DEPARSER_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_pkt_cnt   <= '0;
      stat_trim_cnt  <= '0;
      stat_short_cnt <= '0;
    end else begin
      if (emit && end_pkt) stat_pkt_cnt <= stat_pkt_cnt + 32'd1;
      if (acc && state != ST_FLUSH && state_nxt == ST_FLUSH) stat_trim_cnt <= stat_trim_cnt + 32'd1;
      if (emit && s_axis_tlast && !at_last) stat_short_cnt <= stat_short_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_phv_deparser_trim.sv
// Directed bench for phv_deparser_trim: trimming, header replacement, short
// packets, random output stalls, reset mid-packet and zero-length PHVs.
module tb_phv_deparser_trim;

  localparam int unsigned DW = 256;
  localparam int unsigned TW = 128;
  localparam int unsigned NS = 4;
  localparam int unsigned LW = 16;
  localparam int unsigned BY = DW / 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [DW-1:0]    s_axis_tdata;
  logic [BY-1:0]    s_axis_tkeep;
  logic [TW-1:0]    s_axis_tuser;
  logic             s_axis_tvalid;
  logic             s_axis_tready;
  logic             s_axis_tlast;
  logic [NS*DW-1:0] phv_hdr;
  logic [LW-1:0]    phv_len;
  logic [7:0]       phv_port;
  logic             phv_valid;
  logic             phv_ready;
  logic [DW-1:0]    m_axis_tdata;
  logic [BY-1:0]    m_axis_tkeep;
  logic [TW-1:0]    m_axis_tuser;
  logic             m_axis_tlast;
  logic             m_axis_tvalid;
  logic             m_axis_tready = 1'b1;
`ifdef DEPARSER_STATS_EN
  logic [31:0]      stat_pkt_cnt, stat_trim_cnt, stat_short_cnt;
`endif

  phv_deparser_trim #(
    .DATA_WIDTH (DW), .TUSER_WIDTH (TW), .NUM_SEG (NS), .LEN_WIDTH (LW)
  ) dut (
    .clk (clk), .reset (reset),
    .s_axis_tdata (s_axis_tdata), .s_axis_tkeep (s_axis_tkeep),
    .s_axis_tuser (s_axis_tuser), .s_axis_tvalid (s_axis_tvalid),
    .s_axis_tready (s_axis_tready), .s_axis_tlast (s_axis_tlast),
    .phv_hdr (phv_hdr), .phv_len (phv_len), .phv_port (phv_port),
    .phv_valid (phv_valid), .phv_ready (phv_ready),
    .m_axis_tdata (m_axis_tdata), .m_axis_tkeep (m_axis_tkeep),
    .m_axis_tuser (m_axis_tuser), .m_axis_tlast (m_axis_tlast),
    .m_axis_tvalid (m_axis_tvalid), .m_axis_tready (m_axis_tready)
`ifdef DEPARSER_STATS_EN
    , .stat_pkt_cnt (stat_pkt_cnt), .stat_trim_cnt (stat_trim_cnt),
    .stat_short_cnt (stat_short_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    logic [BY-1:0] keep;
    logic [TW-1:0] user;
    logic          last;
  } beat_t;

  beat_t out_q[$];
  beat_t exp_q[$];
  int    n_cmp = 0, n_bad = 0, pops = 0, viol = 0, npkt = 0;
  bit    rnd_ready = 1'b0;

  task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] in_data(input int p, input int b);
    return {8{8'(p), 8'(b), 16'hA5C3}};
  endfunction

  function automatic logic [TW-1:0] in_user(input int p, input int b);
    return {4{8'(b), 8'(p), 16'h7B1D}};
  endfunction

  function automatic logic [DW-1:0] seg_data(input int p, input int k);
    return {8{8'hC0 + 8'(k), 8'(p), 16'h5EED}};
  endfunction

  // Output monitor: collects accepted beats, counts PHV pops, checks stall hold
  beat_t held;
  bit    stalled = 1'b0;
  always @(negedge clk) begin
    beat_t cur;
    cur.data = m_axis_tdata; cur.keep = m_axis_tkeep;
    cur.user = m_axis_tuser; cur.last = m_axis_tlast;
    if (reset) begin
      stalled = 1'b0;
    end else begin
      if (phv_ready) pops++;
      if (stalled && (!m_axis_tvalid || cur.data !== held.data || cur.keep !== held.keep ||
                      cur.user !== held.user || cur.last !== held.last)) viol++;
      if (m_axis_tvalid && m_axis_tready) out_q.push_back(cur);
      stalled = m_axis_tvalid && !m_axis_tready;
      held = cur;
    end
  end

  always @(posedge clk) begin
    #1;
    m_axis_tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference packet: what the output stream must contain for one PHV/input pair
  task automatic add_exp(input int p, input int len, input int n_in,
                         input logic [BY-1:0] last_keep, input logic [7:0] port);
    int nb, nout, rem;
    logic [BY-1:0] ik;
    beat_t e;
    if (len == 0) return;
    nb   = (len + BY - 1) / BY;
    nout = (nb < n_in) ? nb : n_in;
    rem  = len - BY * (nb - 1);
    for (int b = 0; b < nout; b++) begin
      e.data = (b < NS) ? seg_data(p, b) : in_data(p, b);
      e.user = in_user(p, b);
      if (b == 0) begin
        e.user[15:0]  = 16'(len);
        e.user[31:24] = port;
      end
      ik = (b == n_in - 1) ? last_keep : '1;
      if (b == nb - 1) begin
        e.last = 1'b1;
        for (int i = 0; i < BY; i++) e.keep[i] = (i < rem);
      end else if (b == n_in - 1) begin
        e.last = 1'b1;
        e.keep = ik;
      end else begin
        e.last = 1'b0;
        e.keep = (b < NS) ? '1 : ik;
      end
      exp_q.push_back(e);
    end
  endtask

  task automatic send_beat(input int p, input int b, input logic last, input logic [BY-1:0] keep);
    int t = 0;
    bit got = 1'b0;
    s_axis_tdata  = in_data(p, b);
    s_axis_tuser  = in_user(p, b);
    s_axis_tkeep  = keep;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!got && t < 200) begin
      @(negedge clk);
      got = s_axis_tready;
      @(posedge clk);
      #1;
      t++;
    end
    if (!got) check("beat_accept_timeout", 0, 1);
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_pkt(input int p, input int len, input int n_in,
                          input logic [BY-1:0] last_keep, input logic [7:0] port);
    for (int k = 0; k < int'(NS); k++) phv_hdr[k*DW +: DW] = seg_data(p, k);
    phv_len   = 16'(len);
    phv_port  = port;
    phv_valid = 1'b1;
    for (int b = 0; b < n_in; b++)
      send_beat(p, b, (b == n_in - 1), (b == n_in - 1) ? last_keep : '1);
    check($sformatf("phv_ready_p%0d", p), DW'(phv_ready), 1);
    phv_valid = 1'b0;
    npkt++;
    add_exp(p, len, n_in, last_keep, port);
  endtask

  task automatic drain();
    int t = 0;
    @(posedge clk); #1;
    while (m_axis_tvalid && t < 500) begin
      @(posedge clk); #1;
      t++;
    end
    if (m_axis_tvalid) check("drain_timeout", 0, 1);
  endtask

  task automatic compare_all(input string tag);
    int n;
    drain();
    check($sformatf("%s_count", tag), DW'(out_q.size()), DW'(exp_q.size()));
    n = (out_q.size() < exp_q.size()) ? out_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      check($sformatf("%s_b%0d_data", tag, i), out_q[i].data, exp_q[i].data);
      check($sformatf("%s_b%0d_keep", tag, i), DW'(out_q[i].keep), DW'(exp_q[i].keep));
      check($sformatf("%s_b%0d_user", tag, i), DW'(out_q[i].user), DW'(exp_q[i].user));
      check($sformatf("%s_b%0d_last", tag, i), DW'(out_q[i].last), DW'(exp_q[i].last));
    end
    out_q.delete();
    exp_q.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tuser = '0;
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    phv_hdr = '0; phv_len = '0; phv_port = '0; phv_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_m_tvalid", DW'(m_axis_tvalid), 0);
    check("rst_m_tdata", m_axis_tdata, 0);
    check("rst_m_tkeep", DW'(m_axis_tkeep), 0);
    check("rst_m_tuser", DW'(m_axis_tuser), 0);
    check("rst_m_tlast", DW'(m_axis_tlast), 0);
    check("rst_phv_ready", DW'(phv_ready), 0);
    check("rst_s_tready", DW'(s_axis_tready), 0);
    reset = 1'b0;

    // Test 1: L=64 cuts a 3-beat input to seg0, seg1
    send_pkt(1, 64, 3, '1, 8'h01);
    drain();
    check("t1_n_out", DW'(out_q.size()), 2);
    if (out_q.size() >= 2) begin
      check("t1_b0_data", out_q[0].data, seg_data(1, 0));
      check("t1_b1_last", DW'(out_q[1].last), 1);
      check("t1_b1_keep", DW'(out_q[1].keep), DW'(32'hFFFF_FFFF));
    end
    compare_all("t1");

    // Test 2: L=70 ends in seg2 with 6 valid bytes
    send_pkt(2, 70, 4, '1, 8'h04);
    drain();
    check("t2_n_out", DW'(out_q.size()), 3);
    if (out_q.size() >= 3) begin
      check("t2_b2_keep", DW'(out_q[2].keep), DW'(32'h0000_003F));
      check("t2_b2_last", DW'(out_q[2].last), 1);
      check("t2_b0_len", DW'(out_q[0].user[15:0]), 70);
      check("t2_b0_port", DW'(out_q[0].user[31:24]), DW'(8'h04));
    end
    compare_all("t2");

    // Test 3: L=200 mixes 4 header beats with passthrough
    send_pkt(3, 200, 8, '1, 8'h10);
    drain();
    check("t3_n_out", DW'(out_q.size()), 7);
    if (out_q.size() >= 7) begin
      check("t3_b3_data", out_q[3].data, seg_data(3, 3));
      check("t3_b5_data", out_q[5].data, in_data(3, 5));
      check("t3_b6_keep", DW'(out_q[6].keep), DW'(32'h0000_00FF));
      check("t3_b6_last", DW'(out_q[6].last), 1);
    end
    compare_all("t3");

    // Test 4: short input ends before L
    send_pkt(4, 128, 2, 32'h0000_FFFF, 8'h20);
    drain();
    check("t4_n_out", DW'(out_q.size()), 2);
    if (out_q.size() >= 2) begin
      check("t4_b1_keep", DW'(out_q[1].keep), DW'(32'h0000_FFFF));
      check("t4_b1_last", DW'(out_q[1].last), 1);
    end
    compare_all("t4");
`ifdef DEPARSER_STATS_EN
    check("t4_stat_short", DW'(stat_short_cnt), 1);
    check("t4_stat_trim", DW'(stat_trim_cnt), 3);
    check("t4_stat_pkt", DW'(stat_pkt_cnt), 4);
`endif

    // Test 5: back-to-back packets under random output stalls
    rnd_ready = 1'b1;
    for (int i = 0; i < 20; i++)
      send_pkt(10 + i, 16 + i * 23, 2 + (i % 8), 32'hFFFF_FFFF >> (i % 5), 8'(i));
    compare_all("t5");
    rnd_ready = 1'b0;
    check("t5_stall_hold_viol", DW'(viol), 0);

    // Test 6a: no PHV means no input acceptance
    phv_valid = 1'b0;
    s_axis_tdata = in_data(39, 0);
    s_axis_tvalid = 1'b1;
    @(negedge clk);
    check("t6_no_phv_tready", DW'(s_axis_tready), 0);
    @(posedge clk); #1;
    s_axis_tvalid = 1'b0;

    // Test 6b: reset while in EMIT, then a clean packet
    for (int k = 0; k < int'(NS); k++) phv_hdr[k*DW +: DW] = seg_data(40, k);
    phv_len = 16'd200; phv_port = 8'h55; phv_valid = 1'b1;
    send_beat(40, 0, 1'b0, '1);
    send_beat(40, 1, 1'b0, '1);
    check("t6_in_emit", DW'(dut.state), 1);
    reset = 1'b1;
    @(posedge clk); #1;
    check("t6_rst_m_tvalid", DW'(m_axis_tvalid), 0);
    check("t6_rst_state", DW'(dut.state), 0);
    check("t6_rst_phv_ready", DW'(phv_ready), 0);
    reset = 1'b0;
    phv_valid = 1'b0;
    out_q.delete();
    exp_q.delete();
    send_pkt(41, 96, 3, '1, 8'h08);
    compare_all("t6_after_rst");

    // Test 6c: zero-length PHVs emit nothing but still pop
    send_pkt(42, 0, 2, '1, 8'h00);
    send_pkt(43, 0, 1, '1, 8'h00);
    compare_all("t6_len0");
    check("phv_pop_total", DW'(pops), DW'(npkt));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
